sbox_layer_arbiter: RTL and testbench

- Shares one 4-bit S-box (the `sbox_combinational` instance) between two requesters, for example the round datapath and the key schedule.
- Each requester submits a word of NIBBLES nibbles. The block substitutes one nibble per cycle through the single S-box and returns the whole substituted word with a requester ID.
- Round-robin arbitration between requesters, valid/ready handshakes on both sides, one word in flight at a time.
- S-box mapping (input 0..F -> output): C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2.

---
 rtl/sbox_layer_arbiter.sv | 84 ++++++++
 tb/tb_sbox_layer_arbiter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/sbox_layer_arbiter.sv
// sbox_layer_arbiter: round-robin sharing of one 4-bit S-box between two word requesters
module sbox_combinational (
  input  logic [3:0] x_i,
  output logic [3:0] y_o
);
  localparam logic [63:0] LUT = 64'h2174_8FE3_DA09_B65C;
  assign y_o = LUT[{x_i, 2'b00} +: 4];
endmodule

module sbox_layer_arbiter #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req0_valid,
  input  logic [4*NIBBLES-1:0]   req0_data,
  output logic                   req0_ready,
  input  logic                   req1_valid,
  input  logic [4*NIBBLES-1:0]   req1_data,
  output logic                   req1_ready,
  output logic                   out_valid,
  output logic [4*NIBBLES-1:0]   out_data,
  output logic                   out_id,
  input  logic                   out_ready,
  output logic                   busy
);
  localparam int W  = 4 * NIBBLES;
  localparam int CW = $clog2(NIBBLES);
  typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;
  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [W-1:0]    work_q;
  logic [W-1:0]    out_data_q;
  logic            out_id_q;
  logic            out_valid_q;
  logic            last_grant_q;
  logic [3:0]      sbox_in;
  logic [3:0]      sbox_out;
  assign req0_ready = (state_q == IDLE) && req0_valid && (!req1_valid || last_grant_q);
  assign req1_ready = (state_q == IDLE) && req1_valid && (!req0_valid || !last_grant_q);
  assign sbox_in    = work_q[4*cnt_q +: 4];
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_id     = out_id_q;
  assign busy       = state_q != IDLE;
  sbox_combinational u_sbox (.x_i(sbox_in), .y_o(sbox_out));
  // accept a word, substitute one nibble per cycle LSB first, then hold it until the consumer takes it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      work_q       <= '0;
      out_data_q   <= '0;
      out_id_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE: if (req0_ready || req1_ready) begin
          work_q       <= req1_ready ? req1_data : req0_data;
          out_id_q     <= req1_ready;
          last_grant_q <= req1_ready;
          cnt_q        <= '0;
          state_q      <= SUB;
        end
        SUB: begin
          out_data_q[4*cnt_q +: 4] <= sbox_out;
          if (cnt_q == CW'(NIBBLES - 1)) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            cnt_q       <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: if (out_ready) begin
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sbox_layer_arbiter.sv
// tb_sbox_layer_arbiter: directed vector and sequence checks of the shared S-box arbiter
module tb_sbox_layer_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b0;
  logic [15:0] req0_data = '0;
  logic        req0_ready;
  logic        req1_valid = 1'b0;
  logic [15:0] req1_data = '0;
  logic        req1_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_id;
  logic        out_ready = 1'b1;
  logic        busy;
  int tests = 0;
  int fails = 0;

  sbox_layer_arbiter #(.NIBBLES(4)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .out_valid(out_valid), .out_data(out_data), .out_id(out_id),
    .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        id;
    logic [15:0] din;
    logic [15:0] dout;
  } vec_t;
  vec_t vecs[7];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    step;
    step;
    reset = 1'b0;
  endtask

  task automatic run_word(input logic id, input logic [15:0] din, input logic [15:0] dout);
    int n;
    if (id) begin
      req1_valid = 1'b1;
      req1_data  = din;
    end else begin
      req0_valid = 1'b1;
      req0_data  = din;
    end
    #1;
    check("ready_sel", {30'd0, req1_ready, req0_ready}, id ? 32'd2 : 32'd1);
    step;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_data  = ~din;
    req1_data  = ~din;
    n = 0;
    while (!out_valid && n < 20) begin
      check("busy_sub", {29'd0, busy, req1_ready, req0_ready}, 32'd4);
      step;
      n++;
    end
    check("latency", n, 4);
    check("out_data", {16'd0, out_data}, {16'd0, dout});
    check("out_id", {31'd0, out_id}, {31'd0, id});
    check("out_busy", {31'd0, busy}, 32'd1);
    step;
    check("drain", {30'd0, out_valid, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    int last;
    logic [15:0] held;
    vecs[0] = '{1'b0, 16'h0123, 16'hC56B};
    vecs[1] = '{1'b1, 16'hFEDC, 16'h2174};
    vecs[2] = '{1'b0, 16'h3210, 16'hB65C};
    vecs[3] = '{1'b0, 16'h7654, 16'hDA09};
    vecs[4] = '{1'b0, 16'hBA98, 16'h8FE3};
    vecs[5] = '{1'b0, 16'hFEDC, 16'h2174};
    vecs[6] = '{1'b1, 16'h89AB, 16'h3EF8};
    do_reset;
    check("rst_state", {29'd0, out_valid, out_id, busy}, 32'd0);
    check("rst_data", {16'd0, out_data}, 32'd0);
    check("rst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    for (int i = 0; i < 7; i++) run_word(vecs[i].id, vecs[i].din, vecs[i].dout);

    // both requesters valid continuously from reset: strict alternation starting with requester 0
    reset = 1'b1;
    req0_valid = 1'b1; req0_data = 16'h0000;
    req1_valid = 1'b1; req1_data = 16'hFFFF;
    step; step;
    reset = 1'b0;
    k = 0;
    last = 0;
    for (int c = 1; c <= 60 && k < 4; c++) begin
      step;
      if (out_valid) begin
        check("arb_data", {16'd0, out_data}, k[0] ? 32'h2222 : 32'hCCCC);
        check("arb_id", {31'd0, out_id}, {31'd0, k[0]});
        if (k > 0) check("arb_period", c - last, 6);
        last = c;
        k++;
      end
    end
    check("arb_count", k, 4);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    do_reset;

    // backpressure: result held, no accepts, pending request taken right after handshake
    out_ready = 1'b0;
    req0_valid = 1'b1; req0_data = 16'h7654;
    step;
    req0_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 20) begin step; k++; end
    check("bp_latency", k, 4);
    req1_valid = 1'b1; req1_data = 16'h0123;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("bp_hold", {12'd0, out_valid, out_id, req1_ready, req0_ready, out_data}, 32'h0008_DA09);
      step;
    end
    out_ready = 1'b1;
    #1;
    check("bp_no_accept", {30'd0, req1_ready, out_valid}, 32'd1);
    step;
    held = out_data;
    check("bp_after_hs", {30'd0, req1_ready, out_valid}, 32'd2);
    check("bp_data_kept", {16'd0, held}, 32'h0000_DA09);
    req1_valid = 1'b0;
    run_word(1'b1, 16'h0123, 16'hC56B);

    // reset in the middle of substitution abandons the word
    req0_valid = 1'b1; req0_data = 16'h3210;
    step;
    req0_valid = 1'b0;
    step; step;
    check("mid_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("rst_async", {30'd0, out_valid, busy}, 32'd0);
    check("rst_async_data", {16'd0, out_data}, 32'd0);
    step;
    reset = 1'b0;
    k = 0;
    for (int c = 0; c < 8; c++) begin
      step;
      if (out_valid || busy) k++;
    end
    check("abandoned", k, 0);
    run_word(1'b1, 16'h89AB, 16'h3EF8);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
